mod_mul_p: RTL and testbench
============================

Name: mod_mul_p

Overview:
- Bit-serial interleaved modular multiplier: out_c = in_a * in_b mod P, with P defaulting to the SM2 prime p.
- It is the forward counterpart of the modular inverter. It is used by the SM2 point-arithmetic datapath for field multiplication, and for checking inverter results (a * a^-1 = 1).
- One multiplier bit per clock, MSB first. No DSP or Montgomery domain; plain operands in, plain result out.

Parameters:
- W, 256, operand/result width in bits.
- P, 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF, modulus. It must be odd and satisfy 2^(W-1) < P < 2^W, so that one conditional subtraction always reduces.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset. Synchronous and active-high: sampled only on the rising edge of clk; rst=1 resets the block.
- in_a  in  W  multiplicand; any W-bit value accepted.
- in_b  in  W  multiplier; any W-bit value accepted.
- start  in  1  request; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- out_c  out  W  result; equals r during FIN, 0 otherwise.
- done  out  1  one-cycle pulse, high only in FIN.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, and a_r, b_r, r, cnt all clear to 0. Outputs then read busy=0, done=0, out_c=0.
- Reset has priority over every state, including mid-computation. The computation in progress is abandoned and no done is produced.
- Internal registers:
  - a_r (W bits), b_r (W bits), r (W bits).
  - cnt, log2(W) bits, counting 255 down to 0.
  - one-hot state.
- States:
  - IDLE: if start=1, latch a_r<=in_a, b_r<=in_b, r<=0, then go to LOAD. Otherwise stay.
  - LOAD: a_r <= (a_r >= P) ? a_r-P : a_r, so the multiplicand is reduced below P. Set cnt<=W-1. Go to CALC.
  - CALC, one iteration per cycle using W+2-bit intermediates:
    - t = 2r; t = (t >= P) ? t-P : t
    - u = t + (b_r[W-1] ? a_r : 0); u = (u >= P) ? u-P : u
    - r <= u[W-1:0]; b_r <= b_r << 1; cnt <= cnt-1.
    - If cnt==0, go to FIN; else stay in CALC.
  - FIN: out_c=r and done=1 for exactly this cycle, then go to IDLE.
- Latency: if start is sampled in cycle 0, the block is in LOAD in cycle 1, in CALC in cycles 2..W+1, and in FIN in cycle W+2 (258 for W=256).
- Throughput: a new start is accepted in the cycle after FIN, which is IDLE.
- start while busy=1 is ignored: no queueing, and the latched operands are unaffected.
- Input changes after the start cycle have no effect.
- Invariant: r < P at every CALC edge, so the result is always fully reduced (0 <= out_c < P).
- Boundary cases:
  - in_a=0 or in_b=0 gives 0.
  - in_a=P gives 0.
  - in_b >= P is handled correctly without pre-reduction (Horner's scheme on the raw bits).
- Comparisons are unsigned. No combinational path from inputs to outputs.

Decomposition:
- Shared package:
  - SM2 constants: P_SM2, N_SM2, width 256.
  - The one-hot state encodings of this block, alongside those of the inverter.
- One natural sub-module, mod_add_sub_p: combinational (x+y) mod P with a single conditional subtract. Instantiate it twice in the CALC path (doubling and accumulation) and once for the LOAD reduction, with y=0 and x=a_r. The inverter and the point adder can reuse it later.

Test Plan:
- in_a=1, in_b=5, start pulse -> done exactly 258 cycles after the start edge, out_c=5; busy high for cycles 1..258; out_c=0 before and after.
- in_a=2, in_b=7FFFFFFF7FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF8000000080000000 00000000 ((p+1)/2, without the space) -> out_c=1. Also feed a random a through mod_inv_p, then multiply a by the result -> out_c=1.
- in_a=P-1, in_b=P-1 -> out_c=1. in_a=P+3, in_b=2 -> out_c=6. in_a=0, in_b=P-1 -> out_c=0.
- Bit-exactness: 1000 random (a,b) pairs, each compared against a reference model of (a*b) mod P; no mismatch allowed.
- Assert start at cycles 50 and 100 of an active job with different operands -> ignored; the first job's result is unchanged; exactly one done.
- Assert rst=1 for one cycle at CALC cycle 100 -> next cycle busy=0, done=0, out_c=0, and no done ever follows. A fresh start then completes correctly.

Source files
------------

// File: rtl/mod_mul_p_pkg.sv
// Shared SM2 field constants and the one-hot state encodings of the
// modular multiplier and modular inverter.
package mod_mul_p_pkg;

  localparam int SM2_W = 256;

  localparam logic [SM2_W-1:0] P_SM2 =
    256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF;
  localparam logic [SM2_W-1:0] N_SM2 =
    256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFF7203DF6B21C6052B53BBF40939D54123;

  typedef enum logic [3:0] {
    MUL_IDLE = 4'b0001,
    MUL_LOAD = 4'b0010,
    MUL_CALC = 4'b0100,
    MUL_FIN  = 4'b1000
  } mul_state_t;

  typedef enum logic [5:0] {
    INV_IDLE  = 6'b000001,
    INV_LOAD  = 6'b000010,
    INV_SHIFT = 6'b000100,
    INV_SUB   = 6'b001000,
    INV_CORR  = 6'b010000,
    INV_FIN   = 6'b100000
  } inv_state_t;

endpackage

// File: rtl/mod_add_sub_p.sv
// Combinational (x + y) mod P with one conditional subtraction.
// Callers guarantee x + y < 2P so a single subtract fully reduces.
module mod_add_sub_p #(
  parameter int             W = 256,
  parameter logic [W-1:0]   P = '1
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] z
);

  logic [W:0] s;

  assign s = {1'b0, x} + {1'b0, y};
  assign z = (s >= {1'b0, P}) ? W'(s - {1'b0, P}) : s[W-1:0];

endmodule

// File: rtl/mod_mul_p.sv
// Bit-serial interleaved modular multiplier: out_c = in_a * in_b mod P,
// one multiplier bit per clock, MSB first (Horner's scheme).
module mod_mul_p
  import mod_mul_p_pkg::*;
#(
  parameter int           W = SM2_W,
  parameter logic [W-1:0] P = P_SM2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         start,
  output logic         busy,
  output logic [W-1:0] out_c,
  output logic         done
);

  localparam int CNT_W = $clog2(W);

  mul_state_t       state, state_nxt;
  logic [W-1:0]     a_r, b_r, r;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     a_red, t, u, addend;

  // Multiplicand may be >= P on entry; one subtract brings it below P.
  mod_add_sub_p #(.W(W), .P(P)) u_load (.x(a_r), .y('0),     .z(a_red));
  mod_add_sub_p #(.W(W), .P(P)) u_dbl  (.x(r),   .y(r),      .z(t));
  mod_add_sub_p #(.W(W), .P(P)) u_acc  (.x(t),   .y(addend), .z(u));

  assign addend = b_r[W-1] ? a_r : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MUL_IDLE;
      a_r   <= '0;
      b_r   <= '0;
      r     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        MUL_IDLE: begin
          if (start) begin
            a_r <= in_a;
            b_r <= in_b;
            r   <= '0;
          end
        end
        MUL_LOAD: begin
          a_r <= a_red;
          cnt <= CNT_W'(W - 1);
        end
        MUL_CALC: begin
          r   <= u;
          b_r <= b_r << 1;
          cnt <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    out_c     = '0;
    unique case (state)
      MUL_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = MUL_LOAD;
      end
      MUL_LOAD: state_nxt = MUL_CALC;
      MUL_CALC: if (cnt == '0) state_nxt = MUL_FIN;
      MUL_FIN: begin
        done      = 1'b1;
        out_c     = r;
        state_nxt = MUL_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = MUL_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mod_mul_p.sv
// Bench for mod_mul_p: directed vectors with hand-computed results,
// expected values queued by the driver and checked by a separate monitor.
module tb_mod_mul_p;

  localparam int W = 256;
  localparam logic [W-1:0] P =
    256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF;
  localparam logic [W-1:0] HALF =
    256'h7FFFFFFF7FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF800000008000000000000000;
  localparam logic [W-1:0] ONES_RED =
    256'h0000000100000000000000000000000000000000FFFFFFFF0000000000000000;
  localparam int LAT = 258;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_a, in_b, out_c;
  logic         start, busy, done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [W-1:0] mon_val;
  int           mon_cyc;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mod_mul_p dut (
    .clk   (clk),
    .rst   (rst),
    .in_a  (in_a),
    .in_b  (in_b),
    .start (start),
    .busy  (busy),
    .out_c (out_c),
    .done  (done)
  );

  // Monitor: every done must match the head of the queue, at the right cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: out_c=%h at cyc=%0d, required no done", out_c, cyc);
        end else begin
          mon_val = exp_q.pop_front();
          mon_cyc = exp_cyc_q.pop_front();
          total++;
          if (out_c !== mon_val) begin
            bad++;
            $display("FAIL result: out_c=%h required=%h", out_c, mon_val);
          end
          total++;
          if (cyc != mon_cyc) begin
            bad++;
            $display("FAIL latency: done at cyc=%0d required cyc=%0d", cyc, mon_cyc);
          end
        end
      end else begin
        total++;
        if (out_c !== '0) begin
          bad++;
          $display("FAIL out_c_idle: out_c=%h required=0 at cyc=%0d", out_c, cyc);
        end
      end
    end
  end

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return W'(prod % {{W{1'b0}}, P});
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%h required=%h", name, act, req);
    end
  endtask

  // Pulse start for one edge, then scramble inputs to show they are not reused.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit expect_done, input logic [W-1:0] ev);
    @(negedge clk);
    in_a  = a;
    in_b  = b;
    start = 1'b1;
    if (expect_done) begin
      exp_q.push_back(ev);
      exp_cyc_q.push_back(cyc + LAT);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    in_a  = rand_word();
    in_b  = rand_word();
  endtask

  task automatic wait_idle(output int busy_cycles);
    bit ok;
    ok = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      else if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL timeout: busy=%0b pending=%0d required idle", busy, exp_q.size());
    end
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] ev);
    int bc;
    issue(a, b, 1'b1, ev);
    wait_idle(bc);
  endtask

  initial begin
    int bc;
    logic [W-1:0] ra, rb;
    rst   = 1'b1;
    start = 1'b0;
    in_a  = '0;
    in_b  = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", W'(busy), '0);
    check("reset_done", W'(done), '0);
    check("reset_out_c", out_c, '0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // 1*5 with busy-duration check.
    issue(W'(1), W'(5), 1'b1, W'(5));
    wait_idle(bc);
    check("busy_cycles", W'(bc), W'(LAT));

    run(W'(2), HALF, W'(1));
    run(P - W'(1), P - W'(1), W'(1));
    run(P + W'(3), W'(2), W'(6));
    run('0, P - W'(1), '0);
    run(P, W'(12345), '0);
    run(W'(3), P + W'(1), W'(3));
    run('1, W'(1), ONES_RED);
    run(W'(5), '0, '0);

    // Starts during an active job are ignored.
    issue(W'(7), W'(9), 1'b1, W'(63));
    repeat (48) @(negedge clk);
    in_a = W'(11); in_b = W'(13); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (49) @(negedge clk);
    in_a = W'(17); in_b = W'(19); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_idle(bc);

    // Reset mid-computation abandons the job.
    issue(W'(21), W'(23), 1'b0, '0);
    repeat (101) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", W'(busy), '0);
    check("abort_done", W'(done), '0);
    check("abort_out_c", out_c, '0);
    repeat (300) @(negedge clk);
    run(W'(21), W'(23), W'(483));

    for (int k = 0; k < 12; k++) begin
      ra = rand_word();
      rb = rand_word();
      run(ra, rb, ref_mul(ra, rb));
    end

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending: %0d results never produced, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
